// File: rtl/logic_unit_nb.sv
// logic_unit_nb
//   Two-stage pipelined N-bit bitwise logic unit with valid/ready handshakes
//   on both sides, a registered zero flag, an accumulate mode that uses the
//   previous result in place of x, and a wrapping completed-operation counter.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 1)
//   CNT_W  width of the completed-operation counter
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   transaction present on x/y/op/acc
//   in_ready   block accepts a transaction this cycle (combinational from out_ready)
//   x, y       operands (x ignored when acc=1, y ignored for NOT/PASS)
//   op         3-bit opcode: AND NAND OR NOR XOR XNOR NOT-x PASS-x
//   acc        1 = substitute the previous result for x
//   out_valid  result present on out
//   out_ready  consumer accepts the result this cycle
//   out        result
//   zero       registered, 1 when out_valid and out == 0
//   op_count   number of output handshakes, modulo 2^CNT_W
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds its data stable while valid && !ready, and
// ready may depend combinationally on the downstream ready.
module logic_unit_nb #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  input  logic             acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);

  // Stage 1 holding registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s1_acc_q, s1_acc_d;

  // Stage 2 (output) registers and accumulator
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             s2_free;
  logic             transfer;
  logic             accept;
  logic             out_hs;
  logic [WIDTH-1:0] eff_x;
  logic [WIDTH-1:0] result;

  assign s2_free  = !out_valid_q || out_ready;
  assign transfer = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // acc_q always holds the result of the most recent transfer, so an acc
  // transaction sitting in s1 sees its immediate predecessor's result even
  // when both move on the same edge.
  assign eff_x = s1_acc_q ? acc_q : s1_x_q;

  always_comb begin
    result = '0;
    unique case (s1_op_q)
      3'b000: result = eff_x & s1_y_q;
      3'b001: result = ~(eff_x & s1_y_q);
      3'b010: result = eff_x | s1_y_q;
      3'b011: result = ~(eff_x | s1_y_q);
      3'b100: result = eff_x ^ s1_y_q;
      3'b101: result = ~(eff_x ^ s1_y_q);
      3'b110: result = ~eff_x;
      3'b111: result = eff_x;
      default: result = '0;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_op_d     = s1_op_q;
    s1_acc_d    = s1_acc_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    acc_d       = acc_q;
    op_count_d  = op_count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_x_d     = x;
      s1_y_d     = y;
      s1_op_d    = op;
      s1_acc_d   = acc;
    end else if (transfer) begin
      s1_valid_d = 1'b0;
    end

    if (transfer) begin
      out_valid_d = 1'b1;
      out_d       = result;
      zero_d      = (result == '0);
      acc_d       = result;
    end else if (out_hs) begin
      // out keeps its last value; zero only flags a valid result
      out_valid_d = 1'b0;
      zero_d      = 1'b0;
    end

    if (out_hs) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_op_q     <= '0;
      s1_acc_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_op_q     <= s1_op_d;
      s1_acc_q    <= s1_acc_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
      op_count_q  <= op_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_nb.sv
module tb_logic_unit_nb;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [2:0]   op = '0;
  logic         acc = 1'b0;
  logic         out_ready = 1'b1;

  logic         in_ready, out_valid, zero;
  logic [W-1:0] out;
  logic [7:0]   op_count;

  logic         in_ready_c2, out_valid_c2, zero_c2;
  logic [W-1:0] out_c2;
  logic [1:0]   op_count_c2;

  logic_unit_nb #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .acc(acc), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zero(zero), .op_count(op_count)
  );

  // Same stimulus, narrow counter to exercise the wrap
  logic_unit_nb #(.WIDTH(W), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c2),
    .x(x), .y(y), .op(op), .acc(acc), .out_valid(out_valid_c2),
    .out_ready(out_ready), .out(out_c2), .zero(zero_c2), .op_count(op_count_c2)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_acc = '0;
  int           m_cnt = 0;

  function automatic logic [W-1:0] ref_op(input logic [2:0] o,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [W-1:0] ones;
    ones = '1;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (o)
        3'd0: r[i] = a[i] && b[i];
        3'd1: r[i] = !(a[i] && b[i]);
        3'd2: r[i] = a[i] || b[i];
        3'd3: r[i] = !(a[i] || b[i]);
        3'd4: r[i] = a[i] != b[i];
        3'd5: r[i] = a[i] == b[i];
        3'd6: r[i] = !a[i];
        default: r[i] = a[i];
      endcase
    end
    return r & ones;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_out;
  logic         prev_zero;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] ex;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      n_vec++;
      if (op_count !== 8'(m_cnt)) begin
        n_err++;
        $display("FAIL op_count: got %0d expected %0d", op_count, 8'(m_cnt));
      end
      n_vec++;
      if (op_count_c2 !== 2'(m_cnt)) begin
        n_err++;
        $display("FAIL op_count_c2: got %0d expected %0d", op_count_c2, 2'(m_cnt));
      end
      // at most two buffered: stalled only when both slots hold work
      n_vec++;
      if (in_ready !== !(exp_q.size() == 2 && !out_ready)) begin
        n_err++;
        $display("FAIL in_ready: got %b with %0d outstanding, out_ready=%b",
                 in_ready, exp_q.size(), out_ready);
      end
      if (stall_prev) begin
        n_vec++;
        if (out_valid !== 1'b1 || out !== prev_out || zero !== prev_zero) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b out=%b z=%b expected v=1 out=%b z=%b",
                   out_valid, out, zero, prev_out, prev_zero);
        end
      end
      if (out_valid !== 1'b1) begin
        n_vec++;
        if (zero !== 1'b0) begin
          n_err++;
          $display("FAIL zero_idle: got %b expected 0", zero);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_out: got out=%b expected no result", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e || zero !== (e == '0)) begin
            n_err++;
            $display("FAIL result: got out=%b zero=%b expected out=%b zero=%b",
                     out, zero, e, (e == '0));
          end
        end
        m_cnt++;
      end
      if (in_valid && in_ready === 1'b1) begin
        ex = acc ? m_acc : x;
        e = ref_op(op, ex, y);
        m_acc = e;
        exp_q.push_back(e);
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = out;
      prev_zero  = zero;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] xv,
                       input logic [W-1:0] yv, input logic a);
    in_valid = v;
    op = o;
    x = xv;
    y = yv;
    acc = a;
  endtask

  // called at posedge+1; asserts reset mid-cycle and releases it after two edges
  task automatic apply_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    int guard;
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
      tick();
      guard++;
    end
    n_vec++;
    if (exp_q.size() != 0 || out_valid) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    // put a result into s2 and hold it there
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 4'b0101, 4'b0010, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    #1;
    n_vec++;
    if (out !== '0 || out_valid !== 1'b0 || zero !== 1'b0 || op_count !== 8'd0 ||
        in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got out=%b v=%b z=%b cnt=%0d rdy=%b expected 0 0 0 0 1",
               out, out_valid, zero, op_count, in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: got rdy=%b v=%b expected 1 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 4'b1000, 4'b1001, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out !== 4'b1000) begin
      n_err++;
      $display("FAIL single_and: got v=%b out=%b expected 1 1000", out_valid, out);
    end
    drive(1'b1, 3'd1, 4'b1101, 4'b0110, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out !== 4'b1011) begin
      n_err++;
      $display("FAIL single_nand: got v=%b out=%b expected 1 1011", out_valid, out);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] tab [8];
    tab = '{4'b0100, 4'b1011, 4'b1111, 4'b0000, 4'b1011, 4'b0100, 4'b0010, 4'b1101};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, 3'(i), 4'b1101, 4'b0110, 1'b0);
      else in_valid = 1'b0;
      tick();
      if (i >= 1) begin
        n_vec++;
        if (out_valid !== 1'b1 || out !== tab[i-1] || zero !== (i - 1 == 3)) begin
          n_err++;
          $display("FAIL b2b_op%0d: got v=%b out=%b z=%b expected 1 %b %b",
                   i - 1, out_valid, out, zero, tab[i-1], (i - 1 == 3));
        end
      end
    end
    tick();
    n_vec++;
    if (op_count !== 8'd8 || op_count_c2 !== 2'd0) begin
      n_err++;
      $display("FAIL b2b_count: got %0d/%0d expected 8/0", op_count, op_count_c2);
    end
    drain();
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 4'b1100, 4'b1010, 1'b0);
    tick();
    drive(1'b1, 3'd2, 4'b0001, 4'b0010, 1'b0);
    tick();
    drive(1'b1, 3'd4, 4'b1111, 4'b0101, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 4'b1000) begin
        n_err++;
        $display("FAIL bp_stall%0d: got rdy=%b v=%b out=%b expected 0 1 1000",
                 i, in_ready, out_valid, out);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out !== 4'b0011) begin
      n_err++;
      $display("FAIL bp_second: got out=%b expected 0011", out);
    end
    drain();
    n_vec++;
    if (op_count !== 8'd3) begin
      n_err++;
      $display("FAIL bp_count: got %0d expected 3", op_count);
    end
  endtask

  task automatic test_accumulate();
    logic [W-1:0] tab [4];
    logic [2:0]   ops [4];
    logic [W-1:0] ys [4];
    tab = '{4'b1010, 4'b1100, 4'b0100, 4'b1000};
    ops = '{3'd7, 3'd4, 3'd0, 3'd3};
    ys  = '{4'b0000, 4'b0110, 4'b0100, 4'b0011};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b1, ops[0], 4'b1010, ys[0], 1'b0);
      else if (i < 4) drive(1'b1, ops[i], W'($urandom_range(0, 15)), ys[i], 1'b1);
      else in_valid = 1'b0;
      tick();
      if (i >= 1) begin
        n_vec++;
        if (out_valid !== 1'b1 || out !== tab[i-1]) begin
          n_err++;
          $display("FAIL acc_step%0d: got v=%b out=%b expected 1 %b",
                   i - 1, out_valid, out, tab[i-1]);
        end
      end
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL acc_done: got v=%b expected 0", out_valid);
    end
    drain();
  endtask

  task automatic test_wrap_midreset();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b0);
      tick();
    end
    drain();
    n_vec++;
    if (op_count_c2 !== 2'd1 || op_count !== 8'd5) begin
      n_err++;
      $display("FAIL wrap: got %0d/%0d expected 1/5", op_count_c2, op_count);
    end
    // fill s1 and s2, then reset in flight
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 4'b1111, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 3'd7, 4'b0110, 4'b0000, 1'b0);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_full: got rdy=%b expected 0", in_ready);
    end
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_discard%0d: got v=%b expected 0", i, out_valid);
      end
      tick();
    end
    drive(1'b1, 3'd2, 4'b1111, 4'b0001, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out !== 4'b0001) begin
      n_err++;
      $display("FAIL midreset_acc: got v=%b out=%b expected 1 0001", out_valid, out);
    end
    drain();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      // hold an offered transaction until it is taken
      if (!in_valid || in_ready) begin
        drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_accumulate();
    test_wrap_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
